nr_iter_ctrl: RTL and testbench

//  Sequencer for one Newton-Raphson solve: loads x0, then loops eval f(x)/J(x) -> first_invJ

---
 rtl/nr_pkg.sv | 35 +++
 rtl/nr_watchdog.sv | 42 ++++
 rtl/nr_iter_ctrl.sv | 149 ++++++++++++++
 tb/tb_nr_iter_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/nr_pkg.sv
// Shared types and defaults for the Newton-Raphson iteration sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package nr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_INV,
    S_UPD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  typedef struct packed {
    logic load_x0;
    logic eval_start;
    logic inv_start;
    logic x_upd_en;
  } strobe_t;

  localparam int STROBE_W        = $bits(strobe_t);
  localparam int DEF_MAX_ITER    = 16;
  localparam int DEF_ITER_W      = 5;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_TO_W        = 8;

  // The only states in which the sequencer waits on the datapath.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_EVAL) || (s == S_INV);
  endfunction

endpackage

// File: rtl/nr_watchdog.sv
// Wait-cycle watchdog: clear/enable/expire counter for datapath handshakes.
// Latency: expire is combinational on the TIMEOUT_CYC-th enabled cycle after clear.
// Backpressure: none; counter saturates until cleared.
module nr_watchdog
  import nr_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TO_W        = DEF_TO_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The entry cycle counts as wait cycle zero, so the last allowed cycle sees LAST_CNT.
  assign expire = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/nr_iter_ctrl.sv
// Newton-Raphson solve sequencer: load x0, then eval -> inverse -> update -> check loop.
// Latency: start->load_x0 1 clk; one iteration is 4 clk with a zero-wait datapath.
// Backpressure: waits on eval_done/inv_valid with a watchdog; abort returns to IDLE.
module nr_iter_ctrl
  import nr_pkg::*;
#(
  parameter int MAX_ITER    = DEF_MAX_ITER,
  parameter int ITER_W      = DEF_ITER_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TO_W        = DEF_TO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              eval_done,
  input  logic              inv_valid,
  input  logic              conv_flag,
  output logic              load_x0,
  output logic              eval_start,
  output logic              inv_start,
  output logic              x_upd_en,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              err_timeout,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  state_e              state_q, state_d;
  strobe_t             strb_q, strb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                conv_q, conv_d;
  logic                err_q, err_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                wd_clr;
  logic                wd_en;
  logic                wd_expire;

  nr_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Next state: abort outranks every completion, flag and watchdog event.
  always_comb begin
    state_d = state_q;
    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_LOAD;
        S_LOAD:  state_d = S_EVAL;
        S_EVAL: begin
          if (eval_done)      state_d = S_INV;
          else if (wd_expire) state_d = S_ERR;
        end
        S_INV: begin
          if (inv_valid)      state_d = S_UPD;
          else if (wd_expire) state_d = S_ERR;
        end
        S_UPD:   state_d = S_CHECK;
        S_CHECK: begin
          if (conv_flag || (iter_q == ITER_LIMIT)) state_d = S_DONE;
          else                                     state_d = S_EVAL;
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the transition so every strobe leaves a flop.
  always_comb begin
    strb_d            = '0;
    strb_d.load_x0    = (state_d == S_LOAD);
    strb_d.eval_start = (state_d == S_EVAL) && (state_q != S_EVAL);
    strb_d.inv_start  = (state_d == S_INV) && (state_q != S_INV);
    strb_d.x_upd_en   = (state_d == S_UPD);
    busy_d            = (state_d != S_IDLE);
    done_d            = (state_d == S_DONE);
    conv_d            = conv_q;
    err_d             = err_q;
    iter_d            = iter_q;

    if ((state_q == S_IDLE) && start) begin
      conv_d = 1'b0;
      err_d  = 1'b0;
      iter_d = '0;
    end
    if ((state_q != S_IDLE) && abort) begin
      conv_d = 1'b0;
    end
    // Counting on UPD entry keeps iter_cnt in step with the x_upd_en actually issued.
    if (state_d == S_UPD) begin
      iter_d = iter_q + 1'b1;
    end
    if ((state_q == S_CHECK) && (state_d == S_DONE)) begin
      conv_d = conv_flag;
    end
    if (state_d == S_ERR) begin
      err_d = 1'b1;
    end
  end

  assign wd_clr = strb_d.eval_start || strb_d.inv_start;
  assign wd_en  = is_wait_state(state_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      strb_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      err_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      conv_q  <= conv_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
    end
  end

  assign load_x0     = strb_q.load_x0;
  assign eval_start  = strb_q.eval_start;
  assign inv_start   = strb_q.inv_start;
  assign x_upd_en    = strb_q.x_upd_en;
  assign busy        = busy_q;
  assign done        = done_q;
  assign converged   = conv_q;
  assign err_timeout = err_q;
  assign iter_cnt    = iter_q;

endmodule

// File: tb/tb_nr_iter_ctrl.sv
// Directed bench for nr_iter_ctrl: per-cycle vector table plus hand-written corner sequences.
module tb_nr_iter_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       eval_done;
  logic       inv_valid;
  logic       conv_flag;
  logic       load_x0;
  logic       eval_start;
  logic       inv_start;
  logic       x_upd_en;
  logic       busy;
  logic       done;
  logic       converged;
  logic       err_timeout;
  logic [4:0] iter_cnt;

  nr_iter_ctrl #(
    .MAX_ITER    (4),
    .ITER_W      (5),
    .TIMEOUT_CYC (8),
    .TO_W        (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .eval_done   (eval_done),
    .inv_valid   (inv_valid),
    .conv_flag   (conv_flag),
    .load_x0     (load_x0),
    .eval_start  (eval_start),
    .inv_start   (inv_start),
    .x_upd_en    (x_upd_en),
    .busy        (busy),
    .done        (done),
    .converged   (converged),
    .err_timeout (err_timeout),
    .iter_cnt    (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input bits {start, abort, eval_done, inv_valid, conv_flag}.
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] ST   = 5'b10000;
  localparam logic [4:0] AB   = 5'b01000;
  localparam logic [4:0] ED   = 5'b00100;
  localparam logic [4:0] IV   = 5'b00010;
  localparam logic [4:0] CF   = 5'b00001;
  // Output flags {load_x0, eval_start, inv_start, x_upd_en, busy, done, converged, err_timeout}.
  localparam logic [7:0] Z  = 8'h00;
  localparam logic [7:0] L  = 8'h80;
  localparam logic [7:0] ES = 8'h40;
  localparam logic [7:0] IS = 8'h20;
  localparam logic [7:0] UP = 8'h10;
  localparam logic [7:0] B  = 8'h08;
  localparam logic [7:0] D  = 8'h04;
  localparam logic [7:0] C  = 8'h02;

  typedef struct packed {
    logic [4:0]  in;
    logic [12:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] outs;
  int          errors = 0;
  int          checks = 0;
  int          loads  = 0;
  int          n;
  logic        saw_done;

  assign outs = {load_x0, eval_start, inv_start, x_upd_en, busy, done, converged,
                 err_timeout, iter_cnt};

  task automatic add(input logic [4:0] in, input logic [7:0] fl, input int it);
    vec_t v;
    v.in  = in;
    v.exp = {fl, 5'(it)};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (load_x0) loads++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    eval_done = 1'b0; inv_valid = 1'b0; conv_flag = 1'b0;

    // Scenario 1: eval_done 2 clk after eval_start, inv_valid 5 clk after inv_start,
    // converges on the third CHECK.
    add(ST, L | B, 0);
    add(NONE, ES | B, 0);
    for (int k = 1; k <= 3; k++) begin
      add(NONE, B, k - 1);
      add(NONE, B, k - 1);
      add(ED, IS | B, k - 1);
      repeat (5) add(NONE, B, k - 1);
      add(IV, UP | B, k);
      add(NONE, B, k);
      if (k < 3) add(NONE, ES | B, k);
      else       add(CF, D | C | B, 3);
    end
    add(NONE, C, 3);

    // Scenario 2: zero-wait datapath, never converges, stops at MAX_ITER=4.
    add(ST, L | B, 0);
    add(NONE, ES | B, 0);
    for (int k = 1; k <= 4; k++) begin
      add(ED, IS | B, k - 1);
      add(IV, UP | B, k);
      add(NONE, B, k);
      if (k < 4) add((k == 2) ? (ED | IV) : NONE, ES | B, k);
      else       add(NONE, D | B, 4);
    end
    add(NONE, Z, 4);

    // Scenario 4: abort together with inv_valid in INV, then an immediate clean solve.
    add(ST, L | B, 0);
    add(NONE, ES | B, 0);
    add(ED, IS | B, 0);
    add(AB | IV, Z, 0);
    add(ST, L | B, 0);
    add(NONE, ES | B, 0);
    add(ED, IS | B, 0);
    add(IV, UP | B, 1);
    add(NONE, B, 1);
    add(CF, D | C | B, 1);
    add(NONE, C, 1);
    add(AB, C, 1);
    add(ED | IV, C, 1);

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(outs), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'(outs), 32'd0);

    foreach (vecs[i]) begin
      {start, abort, eval_done, inv_valid, conv_flag} = vecs[i].in;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
    end
    {start, abort, eval_done, inv_valid, conv_flag} = NONE;

    // Scenario 3: inv_valid never arrives -> ERR 8 clk after inv_start.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    eval_done = 1'b1; tick(); eval_done = 1'b0;
    check("t3_inv_start", 32'(inv_start), 32'd1);
    n = 0;
    saw_done = 1'b0;
    while (!err_timeout && (n < 20)) begin
      tick();
      n++;
      if (done) saw_done = 1'b1;
    end
    check("t3_timeout_latency", 32'(n), 32'd8);
    check("t3_err_busy", 32'(busy), 32'd1);
    tick();
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_err_sticky", 32'(err_timeout), 32'd1);
    check("t3_no_done", 32'(saw_done | done), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("t3_start_clears_err", 32'({load_x0, err_timeout}), 32'b10);

    // Completion on the watchdog's last cycle wins over the timeout.
    tick();
    eval_done = 1'b1; tick(); eval_done = 1'b0;
    repeat (7) tick();
    inv_valid = 1'b1; tick(); inv_valid = 1'b0;
    check("t3_completion_wins", 32'({x_upd_en, err_timeout, iter_cnt}), 32'({2'b10, 5'd1}));
    abort = 1'b1; tick(); abort = 1'b0;
    check("t3_abort_in_upd", 32'({busy, done, converged, iter_cnt}), 32'({3'b000, 5'd1}));

    // Scenario 5: async reset mid-EVAL, stray eval_done afterwards.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("t5_in_eval", 32'({eval_start, busy}), 32'b11);
    #2 rst = 1'b0;
    #1 check("t5_async_reset", 32'(outs), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_held_in_reset", 32'(outs), 32'd0);
    rst = 1'b1;
    eval_done = 1'b1; tick(); eval_done = 1'b0;
    check("t5_stray_eval_done", 32'(outs), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_restart_load", 32'({load_x0, busy}), 32'b11);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t5_abort_load", 32'(busy), 32'd0);

    // Scenario 6: start held high, stray inv_valid during EVAL.
    loads = 0;
    start = 1'b1;
    tick();
    tick();
    check("t6_eval_start", 32'(eval_start), 32'd1);
    inv_valid = 1'b1; tick(); inv_valid = 1'b0;
    check("t6_no_early_inv", 32'({inv_start, x_upd_en, busy}), 32'b001);
    eval_done = 1'b1; tick(); eval_done = 1'b0;
    check("t6_inv_start", 32'(inv_start), 32'd1);
    inv_valid = 1'b1; tick(); inv_valid = 1'b0;
    tick();
    conv_flag = 1'b1; tick(); conv_flag = 1'b0;
    check("t6_done", 32'({done, converged, iter_cnt}), 32'({2'b11, 5'd1}));
    start = 1'b0;
    repeat (4) tick();
    check("t6_single_solve", 32'(loads), 32'd1);
    check("t6_idle", 32'({busy, converged}), 32'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
